// File: rtl/g_reg_file_sb_if.sv
// Decode / write-back bundle of the general register file with reservation scoreboard.
// Member names keep their _i/_o suffixes as seen from the register file.
interface g_reg_file_sb_if #(
    parameter int W_OPR = 32,
    parameter int W_RD  = 4,
    parameter int N_WB  = 2
);
    logic [W_RD-1:0]        r0_i;
    logic [W_RD-1:0]        r1_i;
    logic [W_OPR-1:0]       r_opr0_o;
    logic [W_OPR-1:0]       r_opr1_o;
    logic                   reserved0_o;
    logic                   reserved1_o;
    logic                   w_reserve_i;
    logic [W_RD-1:0]        w_reserve_r_i;
    logic                   rsv_full_o;
    logic [N_WB-1:0]        wb_i;
    logic [N_WB*W_RD-1:0]   wb_r_i;
    logic [N_WB*W_OPR-1:0]  result_i;
    logic                   flush_i;
    logic                   err_o;

    modport master (
        output r0_i, r1_i, w_reserve_i, w_reserve_r_i, wb_i, wb_r_i, result_i, flush_i,
        input  r_opr0_o, r_opr1_o, reserved0_o, reserved1_o, rsv_full_o, err_o
    );

    modport slave (
        input  r0_i, r1_i, w_reserve_i, w_reserve_r_i, wb_i, wb_r_i, result_i, flush_i,
        output r_opr0_o, r_opr1_o, reserved0_o, reserved1_o, rsv_full_o, err_o
    );
endinterface

// File: rtl/g_reg_file_sb.sv
// General register file with per-register outstanding-write counters, optional write-back
// bypass onto the two read ports, flush of all reservations and a sticky underflow flag.
module g_reg_file_sb #(
    parameter int W_OPR   = 32,
    parameter int N_REG   = 16,
    parameter int W_RD    = 4,
    parameter int N_WB    = 2,
    parameter int W_CNT   = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             reset,
    g_reg_file_sb_if.slave   bus
);
    // Comparison width wide enough for both the counter and the per-cycle write-back count.
    localparam int W_DEC = $clog2(N_WB + 1);
    localparam int W_CMP = ((W_CNT > W_DEC) ? W_CNT : W_DEC) + 1;
    localparam logic [W_CMP-1:0] CNT_MAX = W_CMP'((1 << W_CNT) - 1);

    logic [W_OPR-1:0] regs_reg [N_REG];
    logic [W_CNT-1:0] cnt_reg  [N_REG];
    logic             err_reg;

    logic [W_RD-1:0]  wb_idx   [N_WB];
    logic [W_OPR-1:0] wb_data  [N_WB];
    logic [W_CMP-1:0] dec      [N_REG];
    logic [W_CMP-1:0] cnt_left [N_REG];
    logic             wr_en    [N_REG];
    logic [W_OPR-1:0] wr_data  [N_REG];
    logic             underflow_any;
    logic             rsv_zero;
    logic             rsv_full;
    logic             rsv_take;

    genvar gi;
    for (gi = 0; gi < N_WB; gi++) begin : g_wb
        assign wb_idx[gi]  = bus.wb_r_i[gi*W_RD +: W_RD];
        assign wb_data[gi] = bus.result_i[gi*W_OPR +: W_OPR];
    end

    // Per register: how many ports hit it, which data wins (highest port), and the drained count.
    always_comb begin
        underflow_any = 1'b0;
        for (int r = 0; r < N_REG; r++) begin
            dec[r]      = '0;
            wr_en[r]    = 1'b0;
            wr_data[r]  = regs_reg[r];
            cnt_left[r] = '0;
            for (int k = 0; k < N_WB; k++) begin
                if (bus.wb_i[k] && (wb_idx[k] == W_RD'(r)) && !((ZERO_R0 != 0) && (r == 0))) begin
                    dec[r]     = dec[r] + W_CMP'(1);
                    wr_en[r]   = 1'b1;
                    wr_data[r] = wb_data[k];
                end
            end
            if (dec[r] > W_CMP'(cnt_reg[r])) begin
                underflow_any = 1'b1;
            end else begin
                cnt_left[r] = W_CMP'(cnt_reg[r]) - dec[r];
            end
        end
    end

    // Fullness is judged after this cycle's write-backs drain the counter.
    assign rsv_zero = (ZERO_R0 != 0) && (bus.w_reserve_r_i == '0);
    assign rsv_full = bus.w_reserve_i && !rsv_zero && (cnt_left[bus.w_reserve_r_i] == CNT_MAX);
    assign rsv_take = bus.w_reserve_i && !rsv_zero && !rsv_full && !bus.flush_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N_REG; r++) begin
                regs_reg[r] <= '0;
                cnt_reg[r]  <= '0;
            end
            err_reg <= 1'b0;
        end else begin
            for (int r = 0; r < N_REG; r++) begin
                if (wr_en[r]) begin
                    regs_reg[r] <= wr_data[r];
                end
                if (bus.flush_i) begin
                    cnt_reg[r] <= '0;
                end else begin
                    cnt_reg[r] <= W_CNT'(cnt_left[r] +
                        ((rsv_take && (bus.w_reserve_r_i == W_RD'(r))) ? W_CMP'(1) : W_CMP'(0)));
                end
            end
            if (underflow_any && !bus.flush_i) begin
                err_reg <= 1'b1;
            end
        end
    end

    for (gi = 0; gi < 2; gi++) begin : g_rd
        logic [W_RD-1:0]  idx;
        logic [W_OPR-1:0] opr;
        logic             rsv;

        assign idx = (gi == 0) ? bus.r0_i : bus.r1_i;

        // wr_data already falls back to the stored value when nothing is written this cycle.
        always_comb begin
            opr = (BYPASS != 0) ? wr_data[idx] : regs_reg[idx];
            rsv = (BYPASS != 0) ? (W_CMP'(cnt_reg[idx]) > dec[idx]) : (cnt_reg[idx] != '0);
            if ((ZERO_R0 != 0) && (idx == '0)) begin
                opr = '0;
                rsv = 1'b0;
            end
        end
    end

    assign bus.r_opr0_o    = g_rd[0].opr;
    assign bus.r_opr1_o    = g_rd[1].opr;
    assign bus.reserved0_o = g_rd[0].rsv;
    assign bus.reserved1_o = g_rd[1].rsv;
    assign bus.rsv_full_o  = rsv_full;
    assign bus.err_o       = err_reg;
endmodule

// File: tb/tb_g_reg_file_sb.sv
// Directed bench for g_reg_file_sb at default parameters (BYPASS=1, ZERO_R0=0, W_CNT=2).
module tb_g_reg_file_sb;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    g_reg_file_sb_if bus ();

    g_reg_file_sb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.r0_i          = '0;
        bus.r1_i          = '0;
        bus.w_reserve_i   = 1'b0;
        bus.w_reserve_r_i = '0;
        bus.wb_i          = '0;
        bus.wb_r_i        = '0;
        bus.result_i      = '0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic set_wb(input int k, input logic [3:0] r, input logic [31:0] d);
        bus.wb_i[k]           = 1'b1;
        bus.wb_r_i[k*4 +: 4]  = r;
        bus.result_i[k*32 +: 32] = d;
    endtask

    task automatic set_rsv(input logic [3:0] r);
        bus.w_reserve_i   = 1'b1;
        bus.w_reserve_r_i = r;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.r_opr0_o !== 32'h0) begin n_fail++; $display("FAIL reset_opr0: got %h, expected %h", bus.r_opr0_o, 32'h0); end
        n_checks++;
        if (bus.reserved0_o !== 1'b0) begin n_fail++; $display("FAIL reset_reserved0: got %b, expected 0", bus.reserved0_o); end
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", bus.err_o); end
        @(negedge clk);
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_write();
        apply_reset();
        bus.r0_i = 4'd5;
        set_wb(0, 4'd3, 32'h1234);
        next_cycle();
        bus.r0_i = 4'd3;
        #1;
        n_checks++;
        if (bus.r_opr0_o !== 32'h1234) begin n_fail++; $display("FAIL write_r3: got %h, expected %h", bus.r_opr0_o, 32'h1234); end
        n_checks++;
        if (bus.reserved0_o !== 1'b0) begin n_fail++; $display("FAIL write_reserved: got %b, expected 0", bus.reserved0_o); end
        $display("test_write done");
    endtask

    task automatic test_reserve_bypass();
        apply_reset();
        bus.r0_i = 4'd5;
        set_rsv(4'd5);
        #1;
        n_checks++;
        if (bus.reserved0_o !== 1'b0) begin n_fail++; $display("FAIL rsv_latency: got %b, expected 0", bus.reserved0_o); end
        next_cycle();
        bus.r0_i = 4'd5;
        #1;
        n_checks++;
        if (bus.reserved0_o !== 1'b1) begin n_fail++; $display("FAIL rsv_visible: got %b, expected 1", bus.reserved0_o); end
        set_wb(0, 4'd5, 32'hAA);
        #1;
        n_checks++;
        if (bus.r_opr0_o !== 32'hAA) begin n_fail++; $display("FAIL bypass_data: got %h, expected %h", bus.r_opr0_o, 32'hAA); end
        n_checks++;
        if (bus.reserved0_o !== 1'b0) begin n_fail++; $display("FAIL bypass_reserved: got %b, expected 0", bus.reserved0_o); end
        next_cycle();
        bus.r0_i = 4'd5;
        #1;
        n_checks++;
        if (bus.r_opr0_o !== 32'hAA) begin n_fail++; $display("FAIL stored_r5: got %h, expected %h", bus.r_opr0_o, 32'hAA); end
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rsv_err: got %b, expected 0", bus.err_o); end
        $display("test_reserve_bypass done");
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_rsv(4'd7);
            next_cycle();
        end
        bus.r1_i = 4'd7;
        set_rsv(4'd7);
        #1;
        n_checks++;
        if (bus.rsv_full_o !== 1'b1) begin n_fail++; $display("FAIL full_4th: got %b, expected 1", bus.rsv_full_o); end
        n_checks++;
        if (bus.reserved1_o !== 1'b1) begin n_fail++; $display("FAIL full_reserved: got %b, expected 1", bus.reserved1_o); end
        next_cycle();
        // Reserve alongside a write-back: drained count 2 leaves room, net count stays 3.
        bus.r1_i = 4'd7;
        set_rsv(4'd7);
        set_wb(0, 4'd7, 32'h70);
        #1;
        n_checks++;
        if (bus.rsv_full_o !== 1'b0) begin n_fail++; $display("FAIL full_with_wb: got %b, expected 0", bus.rsv_full_o); end
        n_checks++;
        if (bus.reserved1_o !== 1'b1) begin n_fail++; $display("FAIL full_wb_reserved: got %b, expected 1", bus.reserved1_o); end
        next_cycle();
        set_rsv(4'd7);
        #1;
        n_checks++;
        if (bus.rsv_full_o !== 1'b1) begin n_fail++; $display("FAIL full_still3: got %b, expected 1", bus.rsv_full_o); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            bus.r1_i = 4'd7;
            set_wb(1, 4'd7, 32'h71 + i);
            #1;
            n_checks++;
            if (bus.reserved1_o !== (i < 2)) begin n_fail++; $display("FAIL drain_%0d: got %b, expected %b", i, bus.reserved1_o, (i < 2)); end
            next_cycle();
        end
        bus.r1_i = 4'd7;
        #1;
        n_checks++;
        if (bus.reserved1_o !== 1'b0) begin n_fail++; $display("FAIL drained: got %b, expected 0", bus.reserved1_o); end
        n_checks++;
        if (bus.r_opr1_o !== 32'h73) begin n_fail++; $display("FAIL drain_data: got %h, expected %h", bus.r_opr1_o, 32'h73); end
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b, expected 0", bus.err_o); end
        $display("test_full done");
    endtask

    task automatic test_collision();
        apply_reset();
        set_rsv(4'd2);
        next_cycle();
        set_rsv(4'd2);
        next_cycle();
        bus.r0_i = 4'd2;
        set_wb(0, 4'd2, 32'h11);
        set_wb(1, 4'd2, 32'h22);
        #1;
        n_checks++;
        if (bus.r_opr0_o !== 32'h22) begin n_fail++; $display("FAIL coll_bypass: got %h, expected %h", bus.r_opr0_o, 32'h22); end
        n_checks++;
        if (bus.reserved0_o !== 1'b0) begin n_fail++; $display("FAIL coll_reserved: got %b, expected 0", bus.reserved0_o); end
        next_cycle();
        bus.r0_i = 4'd2;
        #1;
        n_checks++;
        if (bus.r_opr0_o !== 32'h22) begin n_fail++; $display("FAIL coll_stored: got %h, expected %h", bus.r_opr0_o, 32'h22); end
        n_checks++;
        if (bus.reserved0_o !== 1'b0) begin n_fail++; $display("FAIL coll_cnt0: got %b, expected 0", bus.reserved0_o); end
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL coll_err: got %b, expected 0", bus.err_o); end
        $display("test_collision done");
    endtask

    task automatic test_err();
        apply_reset();
        set_wb(0, 4'd9, 32'h99);
        #1;
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b, expected 0", bus.err_o); end
        next_cycle();
        bus.r0_i = 4'd9;
        #1;
        n_checks++;
        if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b, expected 1", bus.err_o); end
        n_checks++;
        if (bus.r_opr0_o !== 32'h99) begin n_fail++; $display("FAIL err_data: got %h, expected %h", bus.r_opr0_o, 32'h99); end
        next_cycle();
        next_cycle();
        #1;
        n_checks++;
        if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, expected 1", bus.err_o); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b, expected 0", bus.err_o); end
        @(negedge clk);
        reset = 1'b1;
        $display("test_err done");
    endtask

    task automatic test_flush();
        apply_reset();
        set_rsv(4'd1);
        next_cycle();
        set_rsv(4'd4);
        next_cycle();
        bus.r0_i = 4'd1;
        bus.r1_i = 4'd4;
        #1;
        n_checks++;
        if (bus.reserved0_o !== 1'b1 || bus.reserved1_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre: got %b%b, expected 11", bus.reserved0_o, bus.reserved1_o);
        end
        bus.flush_i = 1'b1;
        set_rsv(4'd6);
        set_wb(0, 4'd8, 32'h55);
        next_cycle();
        bus.r0_i = 4'd1;
        bus.r1_i = 4'd4;
        #1;
        n_checks++;
        if (bus.reserved0_o !== 1'b0 || bus.reserved1_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got %b%b, expected 00", bus.reserved0_o, bus.reserved1_o);
        end
        bus.r0_i = 4'd6;
        bus.r1_i = 4'd8;
        #1;
        n_checks++;
        if (bus.reserved0_o !== 1'b0) begin n_fail++; $display("FAIL flush_r6: got %b, expected 0", bus.reserved0_o); end
        n_checks++;
        if (bus.r_opr1_o !== 32'h55) begin n_fail++; $display("FAIL flush_write: got %h, expected %h", bus.r_opr1_o, 32'h55); end
        n_checks++;
        if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b, expected 0", bus.err_o); end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_rsv(4'd8);
        set_wb(1, 4'd10, 32'h77);
        next_cycle();
        bus.r0_i = 4'd10;
        bus.r1_i = 4'd8;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.r_opr0_o !== 32'h0) begin n_fail++; $display("FAIL async_data: got %h, expected %h", bus.r_opr0_o, 32'h0); end
        n_checks++;
        if (bus.reserved1_o !== 1'b0) begin n_fail++; $display("FAIL async_rsv: got %b, expected 0", bus.reserved1_o); end
        @(negedge clk);
        reset = 1'b1;
        $display("test_async_reset done");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_wb(i % 2, 4'(11 + i), 32'hB000 + i);
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            bus.r1_i = 4'(11 + i);
            #1;
            n_checks++;
            if (bus.r_opr1_o !== 32'hB000 + i) begin
                n_fail++; $display("FAIL b2b_r%0d: got %h, expected %h", 11 + i, bus.r_opr1_o, 32'hB000 + i);
            end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write();
        test_reserve_bypass();
        test_full();
        test_collision();
        test_err();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
